// File: rtl/stage_e_mdu_if.sv
`default_nettype none
// ============================================================================
//  Module      : stage_e_mdu_if
//  Description : Execute-stage multiply/divide bus. The pipeline side (master)
//                launches or flushes operations. The MDU side (slave) answers
//                with a busy/stall flag and a one-cycle completion pulse that
//                carries the result and its destination tag.
//  Signals     : StartE, MDOpE[2:0], SrcAE, SrcBE, RdE[4:0], FlushE  (master->slave)
//                BusyE, DoneE, MDResultE, MDRdE[4:0]                  (slave->master)
//  Revision    : 1.0  initial release
// ============================================================================
interface stage_e_mdu_if #(
    parameter int XLEN = 32
);
    logic            StartE;
    logic [2:0]      MDOpE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic [4:0]      RdE;
    logic            FlushE;
    logic            BusyE;
    logic            DoneE;
    logic [XLEN-1:0] MDResultE;
    logic [4:0]      MDRdE;

    modport master (
        output StartE, MDOpE, SrcAE, SrcBE, RdE, FlushE,
        input  BusyE, DoneE, MDResultE, MDRdE
    );

    modport slave (
        input  StartE, MDOpE, SrcAE, SrcBE, RdE, FlushE,
        output BusyE, DoneE, MDResultE, MDRdE
    );
endinterface
`default_nettype wire

// File: rtl/stage_e_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : stage_e_mdu
//  Description : Iterative RV32M / ARM MUL multiply-divide unit for the execute
//                stage. Retires BPC result bits per cycle. Holds the pipeline
//                through BusyE while iterating, then pulses DoneE with the
//                result and its destination tag. Divide-by-zero and signed
//                overflow are resolved at the start edge with 1-cycle latency.
//  Ports       : clk              clock, rising edge
//                rst              asynchronous active-low reset
//                mdu (slave)      StartE/MDOpE/SrcAE/SrcBE/RdE/FlushE in,
//                                 BusyE/DoneE/MDResultE/MDRdE out
//  Parameters  : XLEN  operand width (multiple of BPC)
//                BPC   bits retired per cycle (1, 2 or 4)
//  Revision    : 1.0  initial release
// ============================================================================
module stage_e_mdu #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  wire logic    clk,
    input  wire logic    rst,
    stage_e_mdu_if.slave mdu
);
    localparam int STEPS = XLEN / BPC;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              negres_q;   // product / quotient sign differs from magnitude
    logic              negrem_q;   // remainder takes the dividend sign
    logic [XLEN-1:0]   opnd_q;     // |B|: multiplicand or divisor
    logic [2*XLEN-1:0] acc_q;      // mul: {hi, multiplier}; div: {rem, quotient}
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        mdrd_q;

    // ------------------------------------------------------------------
    // Launch decode: operand signedness, magnitudes and special cases
    // ------------------------------------------------------------------
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_by_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        a_signed    = (mdu.MDOpE == 3'd1) || (mdu.MDOpE == 3'd2) ||
                      (mdu.MDOpE == 3'd4) || (mdu.MDOpE == 3'd6);
        b_signed    = (mdu.MDOpE == 3'd1) || (mdu.MDOpE == 3'd4) || (mdu.MDOpE == 3'd6);
        a_neg       = a_signed & mdu.SrcAE[XLEN-1];
        b_neg       = b_signed & mdu.SrcBE[XLEN-1];
        abs_a       = a_neg ? -mdu.SrcAE : mdu.SrcAE;
        abs_b       = b_neg ? -mdu.SrcBE : mdu.SrcBE;
        div_by_zero = mdu.MDOpE[2] && (mdu.SrcBE == '0);
        div_ovf     = ((mdu.MDOpE == 3'd4) || (mdu.MDOpE == 3'd6)) &&
                      (mdu.SrcAE == INT_MIN) && (mdu.SrcBE == '1);
        special     = div_by_zero | div_ovf;
        // MDOpE[1] separates REM/REMU from DIV/DIVU
        if (div_by_zero) begin
            special_res = mdu.MDOpE[1] ? mdu.SrcAE : '1;
        end else begin
            special_res = mdu.MDOpE[1] ? '0 : mdu.SrcAE;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath: BPC shift-add or restoring-divide steps
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] acc_d;
    logic [XLEN:0]     sh, diff, hi;

    always_comb begin
        acc_d = acc_q;
        sh    = '0;
        diff  = '0;
        hi    = '0;
        for (int i = 0; i < BPC; i++) begin
            if (op_q[2]) begin
                // Shift next dividend bit into the partial remainder, try subtract
                sh   = {acc_d[2*XLEN-1:XLEN], acc_d[XLEN-1]};
                diff = sh - {1'b0, opnd_q};
                if (!diff[XLEN]) begin
                    acc_d = {diff[XLEN-1:0], acc_d[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {sh[XLEN-1:0], acc_d[XLEN-2:0], 1'b0};
                end
            end else begin
                // Conditionally add multiplicand to the high half, then shift right
                hi    = {1'b0, acc_d[2*XLEN-1:XLEN]} + (acc_d[0] ? {1'b0, opnd_q} : '0);
                acc_d = {hi, acc_d[XLEN-1:1]};
            end
        end
    end

    // Sign fix-up and result selection for the final iteration
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, result_d;

    always_comb begin
        prod_fix = negres_q ? -acc_d : acc_d;
        quot_fix = negres_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        rem_fix  = negrem_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:                result_d = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    result_d = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:          result_d = quot_fix;
            default:             result_d = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            negres_q <= 1'b0;
            negrem_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            mdrd_q   <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (mdu.FlushE) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        if (cnt_q == '0) begin
                            result_q <= result_d;
                            mdrd_q   <= rd_q;
                            state_q  <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE both accept a launch (back-to-back from DONE)
                    if (mdu.StartE && !mdu.FlushE) begin
                        op_q     <= mdu.MDOpE;
                        rd_q     <= mdu.RdE;
                        negres_q <= a_neg ^ b_neg;
                        negrem_q <= a_neg;
                        opnd_q   <= abs_b;
                        acc_q    <= {{XLEN{1'b0}}, abs_a};
                        cnt_q    <= CNT_INIT;
                        if (special) begin
                            result_q <= special_res;
                            mdrd_q   <= mdu.RdE;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_RUN;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign mdu.BusyE     = (state_q == S_RUN);
    assign mdu.DoneE     = (state_q == S_DONE);
    assign mdu.MDResultE = result_q;
    assign mdu.MDRdE     = mdrd_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_e_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage_e_mdu
//  Description : Scoreboard bench for stage_e_mdu. Two instances: BPC=1 and
//                BPC=4. Each issued op pushes its expected result, tag and
//                completion cycle; per-instance monitors pop on DoneE.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stage_e_mdu;
    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst1_n, rst4_n;
    int   cyc    = 0;
    int   busy1  = 0;
    int   busy4  = 0;
    int   n_pass = 0;
    int   n_chk  = 0;
    int   b0;
    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;

    stage_e_mdu_if #(.XLEN(32)) if1 ();
    stage_e_mdu_if #(.XLEN(32)) if4 ();

    stage_e_mdu #(.XLEN(32), .BPC(1)) u_dut1 (.clk(clk), .rst(rst1_n), .mdu(if1));
    stage_e_mdu #(.XLEN(32), .BPC(4)) u_dut4 (.clk(clk), .rst(rst4_n), .mdu(if4));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        busy1 <= busy1 + (if1.BusyE ? 1 : 0);
        busy4 <= busy4 + (if4.BusyE ? 1 : 0);
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    // Monitors
    always @(negedge clk) begin
        if (if1.DoneE === 1'b1) begin
            if (q1.size() == 0) begin
                n_chk++;
                $display("FAIL dut1_unexpected_done: got DoneE=1 (rd %0d) expected no completion", if1.MDRdE);
            end else begin
                e1 = q1.pop_front();
                check("dut1_result",  if1.MDResultE, e1.res);
                check("dut1_rd",      {27'b0, if1.MDRdE}, {27'b0, e1.rd});
                check("dut1_latency", 32'(cyc), 32'(e1.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (if4.DoneE === 1'b1) begin
            if (q4.size() == 0) begin
                n_chk++;
                $display("FAIL dut4_unexpected_done: got DoneE=1 (rd %0d) expected no completion", if4.MDRdE);
            end else begin
                e4 = q4.pop_front();
                check("dut4_result",  if4.MDResultE, e4.res);
                check("dut4_rd",      {27'b0, if4.MDRdE}, {27'b0, e4.rd});
                check("dut4_latency", 32'(cyc), 32'(e4.cyc));
            end
        end
    end

    // Drive one launch cycle; caller positions time inside the launch cycle
    task automatic issue(input int sel, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int lat, input bit push);
        exp_t e;
        e.res = exp_res;
        e.rd  = rd;
        e.cyc = cyc + lat;
        if (sel == 1) begin
            if1.StartE = 1'b1; if1.MDOpE = op; if1.SrcAE = a; if1.SrcBE = b; if1.RdE = rd;
            if (push) q1.push_back(e);
        end else begin
            if4.StartE = 1'b1; if4.MDOpE = op; if4.SrcAE = a; if4.SrcBE = b; if4.RdE = rd;
            if (push) q4.push_back(e);
        end
        @(posedge clk);
        #1;
        if1.StartE = 1'b0;
        if4.StartE = 1'b0;
    endtask

    task automatic wait_drain(input int sel);
        int n = 0;
        while ((((sel == 1) ? q1.size() : q4.size()) != 0) && (n < 200)) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_chk++;
        if (((sel == 1) ? q1.size() : q4.size()) == 0) begin
            n_pass++;
        end else begin
            $display("FAIL dut%0d_timeout: got %0d pending results expected 0", sel,
                     (sel == 1) ? q1.size() : q4.size());
            q1.delete();
            q4.delete();
        end
    endtask

    task automatic run(input int sel, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_res, input int lat);
        @(negedge clk);
        issue(sel, op, a, b, rd, exp_res, lat, 1'b1);
        wait_drain(sel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst1_n = 1'b0; rst4_n = 1'b0;
        if1.StartE = 1'b0; if1.FlushE = 1'b0; if1.MDOpE = '0; if1.SrcAE = '0; if1.SrcBE = '0; if1.RdE = '0;
        if4.StartE = 1'b0; if4.FlushE = 1'b0; if4.MDOpE = '0; if4.SrcAE = '0; if4.SrcBE = '0; if4.RdE = '0;
        repeat (2) @(negedge clk);
        check("rst_result1", if1.MDResultE, 32'h0);
        check("rst_rd1",     {27'b0, if1.MDRdE}, 32'h0);
        check("rst_busy1",   {31'b0, if1.BusyE}, 32'h0);
        check("rst_done1",   {31'b0, if1.DoneE}, 32'h0);
        check("rst_result4", if4.MDResultE, 32'h0);
        check("rst_busy4",   {31'b0, if4.BusyE}, 32'h0);
        rst1_n = 1'b1; rst4_n = 1'b1;

        // ---------------- BPC = 1 ----------------
        b0 = busy1;
        run(1, 3'd0, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 33);
        check("mul_busy_cycles", 32'(busy1 - b0), 32'd32);
        run(1, 3'd1, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000, 33);
        run(1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, 33);
        run(1, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 33);
        run(1, 3'd4, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 33);
        run(1, 3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 33);
        run(1, 3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 33);
        run(1, 3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 33);
        run(1, 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1);
        run(1, 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h0, 1);
        b0 = busy1;
        run(1, 3'd4, 32'd123, 32'd0, 5'd9, 32'hFFFFFFFF, 1);
        run(1, 3'd5, 32'd77, 32'd0, 5'd15, 32'hFFFFFFFF, 1);
        run(1, 3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1);
        check("div0_busy_cycles", 32'(busy1 - b0), 32'd0);

        // Flush at RUN cycle 10: no completion, result registers untouched
        @(negedge clk);
        issue(1, 3'd4, 32'd1000, 32'd3, 5'd13, 32'd333, 33, 1'b0);
        repeat (9) @(negedge clk);
        if1.FlushE = 1'b1;
        @(posedge clk); #1;
        if1.FlushE = 1'b0;
        @(negedge clk);
        check("flush_busy",   {31'b0, if1.BusyE}, 32'h0);
        check("flush_result", if1.MDResultE, 32'd5);
        check("flush_rd",     {27'b0, if1.MDRdE}, 32'd10);
        repeat (40) @(negedge clk);

        // Flush and start in the same cycle: op must not launch
        if1.FlushE = 1'b1;
        issue(1, 3'd0, 32'd3, 32'd3, 5'd16, 32'd9, 33, 1'b0);
        if1.FlushE = 1'b0;
        @(negedge clk);
        check("flush_start_busy", {31'b0, if1.BusyE}, 32'h0);
        repeat (40) @(negedge clk);

        run(1, 3'd5, 32'd9, 32'd3, 5'd14, 32'd3, 33);

        // ---------------- BPC = 4 ----------------
        @(negedge clk);
        issue(4, 3'd5, 32'hFFFFFFFF, 32'd16, 5'd20, 32'h0FFFFFFF, 9, 1'b1);
        for (int i = 0; (i < 50) && (if4.DoneE !== 1'b1); i++) begin
            @(negedge clk);
            #1;
        end
        // Launch in the DONE cycle
        issue(4, 3'd7, 32'hFFFFFFFF, 32'd16, 5'd21, 32'd15, 9, 1'b1);
        wait_drain(4);
        b0 = busy4;
        run(4, 3'd0, 32'd7, 32'hFFFFFFFD, 5'd22, 32'hFFFFFFEB, 9);
        check("mul4_busy_cycles", 32'(busy4 - b0), 32'd8);
        run(4, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd26, 32'hFFFFFFFF, 9);
        run(4, 3'd4, 32'hFFFFFFF9, 32'd2, 5'd23, 32'hFFFFFFFD, 9);
        run(4, 3'd6, 32'hFFFFFFF9, 32'd2, 5'd24, 32'hFFFFFFFF, 9);

        // Reset mid-RUN: outputs return to zero immediately, no completion
        @(negedge clk);
        issue(4, 3'd5, 32'd1000, 32'd10, 5'd25, 32'd100, 9, 1'b0);
        repeat (3) @(negedge clk);
        rst4_n = 1'b0;
        #1;
        check("midrst_result", if4.MDResultE, 32'h0);
        check("midrst_rd",     {27'b0, if4.MDRdE}, 32'h0);
        check("midrst_busy",   {31'b0, if4.BusyE}, 32'h0);
        check("midrst_done",   {31'b0, if4.DoneE}, 32'h0);
        @(negedge clk);
        rst4_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
